// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the sequential RISC-V ALU: operation codes,
// FSM state encoding and helpers that classify operation codes.
package riscv_alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'd0;
   localparam logic [3:0] ALU_OR    = 4'd1;
   localparam logic [3:0] ALU_ADD   = 4'd2;
   localparam logic [3:0] ALU_SLL   = 4'd3;
   localparam logic [3:0] ALU_SRL   = 4'd4;
   localparam logic [3:0] ALU_SRA   = 4'd5;
   localparam logic [3:0] ALU_SUB   = 4'd6;
   localparam logic [3:0] ALU_SLT   = 4'd7;
   localparam logic [3:0] ALU_SLTU  = 4'd8;
   localparam logic [3:0] ALU_MUL   = 4'd9;
   localparam logic [3:0] ALU_MULHU = 4'd10;
   localparam logic [3:0] ALU_DIVU  = 4'd11;
   localparam logic [3:0] ALU_XOR   = 4'd12;
   localparam logic [3:0] ALU_REMU  = 4'd13;

   // Operation select for the iterative unit: bit 1 = divide, bit 0 = upper half
   localparam logic [1:0] MD_MUL   = 2'd0;
   localparam logic [1:0] MD_MULHU = 2'd1;
   localparam logic [1:0] MD_DIVU  = 2'd2;
   localparam logic [1:0] MD_REMU  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_t;

   // True for the codes handled by the multi-cycle multiply/divide unit
   function automatic logic is_iterative(input logic [3:0] ctl);
      return (ctl == ALU_MUL) || (ctl == ALU_MULHU) ||
             (ctl == ALU_DIVU) || (ctl == ALU_REMU);
   endfunction

   // Maps an iterative ALU code onto the multiply/divide unit's op select
   function automatic logic [1:0] md_op(input logic [3:0] ctl);
      logic [1:0] op;
      case (ctl)
         ALU_MULHU: op = MD_MULHU;
         ALU_DIVU:  op = MD_DIVU;
         ALU_REMU:  op = MD_REMU;
         default:   op = MD_MUL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/riscv_iter_muldiv.sv
// Iterative unsigned multiply/divide. One step per cycle over a shared
// 2*WIDTH accumulator: shift-add (LSB first) for multiply, restoring
// division for divide. The upper half ends as product-high/remainder,
// the lower half as product-low/quotient. done pulses combinationally
// during the last step and res carries that step's outcome.
module riscv_iter_muldiv
   import riscv_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH);

   logic               active_q, active_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_rem;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_next;

   // One multiply step and one division step, selected by the captured op
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_rem - {1'b0, opb_q};
      div_ge    = (div_rem >= {1'b0, opb_q});
      div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
      step_next = op_q[1] ? div_next : mul_next;
      done      = active_q && (cnt_q == '0);
      res       = op_q[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
   end

   // Next-state: load on start, step while active, stop after the last step
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      if (start && !active_q) begin
         active_d = 1'b1;
         cnt_d    = CW'(WIDTH - 1);
         op_d     = op;
         acc_d    = {{WIDTH{1'b0}}, a};
         opb_d    = b;
      end else if (active_q) begin
         acc_d = step_next;
         if (cnt_q == '0) begin
            active_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // Datapath and counter registers; reset aborts any operation in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         op_q     <= MD_MUL;
         acc_q    <= '0;
         opb_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
      end
   end

endmodule

// File: rtl/riscv_seq_alu.sv
// Sequential RISC-V ALU. Simple ops complete on the accept edge; multiply
// and divide run in riscv_iter_muldiv while the FSM sits in ITER.
// Handshake: an op is accepted on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE with reset low. out_valid pulses for one
// cycle each time result is updated and has no back-pressure.
module riscv_seq_alu
   import riscv_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic             md_start;
   logic             md_done;
   logic [WIDTH-1:0] md_res;
   logic [WIDTH-1:0] simple_res;
   logic [SHW-1:0]   shamt;

   assign in_ready  = (state_q == ST_IDLE) && !reset;
   assign accept    = in_valid && in_ready;
   assign md_start  = accept && is_iterative(alu_ctl);
   assign shamt     = b[SHW-1:0];
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign busy      = (state_q == ST_ITER);

   riscv_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock (clock),
      .reset (reset),
      .start (md_start),
      .op    (md_op(alu_ctl)),
      .a     (a),
      .b     (b),
      .done  (md_done),
      .res   (md_res)
   );

   // Single-cycle operations; undefined codes produce zero
   always_comb begin
      simple_res = '0;
      case (alu_ctl)
         ALU_AND:  simple_res = a & b;
         ALU_OR:   simple_res = a | b;
         ALU_XOR:  simple_res = a ^ b;
         ALU_ADD:  simple_res = a + b;
         ALU_SUB:  simple_res = a - b;
         ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_SLL:  simple_res = a << shamt;
         ALU_SRL:  simple_res = a >> shamt;
         ALU_SRA:  simple_res = WIDTH'($signed(a) >>> shamt);
         default:  simple_res = '0;
      endcase
   end

   // FSM next state, result load and out_valid pulse generation
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_iterative(alu_ctl)) begin
                  state_d = ST_ITER;
               end else begin
                  result_d    = simple_res;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_ITER: begin
            if (md_done) begin
               state_d     = ST_IDLE;
               result_d    = md_res;
               out_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, result and valid registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_riscv_seq_alu.sv
// Directed bench for riscv_seq_alu: a WIDTH=32 instance for the main vector
// table and corner sequences, plus a WIDTH=8 instance for the narrow case.
module tb_riscv_seq_alu;

   logic        clock;
   logic        reset;

   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctl;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   logic        in_valid8;
   logic        in_ready8;
   logic [3:0]  alu_ctl8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        out_valid8;
   logic [7:0]  result8;
   logic        zero8;
   logic        busy8;

   int n_checks;
   int n_pass;

   riscv_seq_alu #(.WIDTH(32)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctl   (alu_ctl),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   riscv_seq_alu #(.WIDTH(8)) dut8 (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .alu_ctl   (alu_ctl8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .result    (result8),
      .zero      (zero8),
      .busy      (busy8)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] va;
      logic [31:0] vb;
      logic [31:0] exp_res;
      logic        exp_zero;
      int          exp_lat;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Issue one op on the selected instance and wait for its out_valid.
   // lat counts falling edges after the accept edge up to the out_valid one.
   task automatic do_op(input bit w8, input logic [3:0] ctl, input logic [31:0] va,
                        input logic [31:0] vb, output logic [31:0] res,
                        output logic zr, output int lat);
      @(negedge clock);
      if (w8) begin
         alu_ctl8 = ctl; a8 = va[7:0]; b8 = vb[7:0]; in_valid8 = 1'b1;
      end else begin
         alu_ctl = ctl; a = va; b = vb; in_valid = 1'b1;
      end
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      in_valid8 = 1'b0;
      lat = 0;
      res = '0;
      zr  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clock);
         lat++;
         if (w8 ? out_valid8 : out_valid) begin
            res = w8 ? {24'd0, result8} : result;
            zr  = w8 ? zero8 : zero;
            break;
         end
         if (k == 99) lat = -1;
      end
   endtask

   initial begin
      logic [31:0] r;
      logic        z;
      int          lat;
      int          busy_cnt;
      int          ready_in_iter;
      int          spurious;

      n_checks = 0;
      n_pass   = 0;
      in_valid = 0; alu_ctl = '0; a = '0; b = '0;
      in_valid8 = 0; alu_ctl8 = '0; a8 = '0; b8 = '0;

      vecs[0]  = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};  // ADD wrap
      vecs[1]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};  // SLT
      vecs[2]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1};  // SLTU
      vecs[3]  = '{4'd5,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1};  // SRA
      vecs[4]  = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1};  // AND
      vecs[5]  = '{4'd1,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1};  // OR
      vecs[6]  = '{4'd12, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1};  // XOR
      vecs[7]  = '{4'd6,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1};  // SUB
      vecs[8]  = '{4'd3,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1};  // SLL, upper b bits ignored
      vecs[9]  = '{4'd4,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1};  // SRL
      vecs[10] = '{4'd14, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1};  // undefined
      vecs[11] = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33}; // MULHU
      vecs[12] = '{4'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33}; // MUL
      vecs[13] = '{4'd9,  32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 33}; // MUL small
      vecs[14] = '{4'd11, 32'd100,       32'd7,         32'd14,        1'b0, 33}; // DIVU
      vecs[15] = '{4'd13, 32'd100,       32'd7,         32'd2,         1'b0, 33}; // REMU
      vecs[16] = '{4'd11, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 33}; // DIVU /0
      vecs[17] = '{4'd13, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 33}; // REMU /0
      vecs[18] = '{4'd15, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1};  // undefined

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_result", result, 32'h0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd1);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Vector table
      for (int i = 0; i < 19; i++) begin
         do_op(1'b0, vecs[i].ctl, vecs[i].va, vecs[i].vb, r, z, lat);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
         check($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      end

      // Back-to-back simple ops, one accept per cycle
      @(negedge clock);
      in_valid = 1'b1; alu_ctl = 4'd2; a = 32'hFFFF_FFFF; b = 32'h1;
      @(negedge clock);
      check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_add_result", result, 32'h0);
      check("b2b_add_zero", {31'd0, zero}, 32'd1);
      alu_ctl = 4'd7; a = 32'hFFFF_FFFF; b = 32'h1;
      @(negedge clock);
      check("b2b_slt_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_slt_result", result, 32'h1);
      alu_ctl = 4'd8;
      @(negedge clock);
      check("b2b_sltu_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_sltu_result", result, 32'h0);
      alu_ctl = 4'd5; a = 32'h8000_0000; b = 32'h4;
      @(negedge clock);
      in_valid = 1'b0;
      check("b2b_sra_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_sra_result", result, 32'hF800_0000);
      @(negedge clock);
      check("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_hold_result", result, 32'hF800_0000);

      // MULHU with in_valid held high throughout ITER
      @(negedge clock);
      in_valid = 1'b1; alu_ctl = 4'd10; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      @(posedge clock);
      #1;
      alu_ctl = 4'd2; a = 32'h1; b = 32'h1;
      busy_cnt = 0; ready_in_iter = 0; lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clock);
         if (busy) busy_cnt++;
         if (busy && in_ready) ready_in_iter++;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      in_valid = 1'b0;
      check("hold_latency", lat, 33);
      check("hold_busy_cycles", busy_cnt, 32);
      check("hold_ready_in_iter", ready_in_iter, 0);
      check("hold_result", result, 32'hFFFF_FFFE);
      @(negedge clock);
      check("hold_no_extra_valid", {31'd0, out_valid}, 32'd0);

      // Reset 10 cycles into a DIVU
      @(negedge clock);
      in_valid = 1'b1; alu_ctl = 4'd11; a = 32'd100; b = 32'd7;
      @(posedge clock);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clock);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_result", result, 32'h0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (out_valid) spurious++;
      end
      check("abort_no_valid", spurious, 0);
      check("abort_result_after", result, 32'h0);
      check("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
      do_op(1'b0, 4'd2, 32'd3, 32'd4, r, z, lat);
      check("abort_next_add", r, 32'd7);
      check("abort_next_lat", lat, 1);

      // WIDTH=8 instance
      do_op(1'b1, 4'd9, 32'h10, 32'h10, r, z, lat);
      check("w8_mul_result", r, 32'h00);
      check("w8_mul_zero", {31'd0, z}, 32'd1);
      check("w8_mul_latency", lat, 9);
      do_op(1'b1, 4'd10, 32'h10, 32'h10, r, z, lat);
      check("w8_mulhu_result", r, 32'h01);
      check("w8_mulhu_zero", {31'd0, z}, 32'd0);
      check("w8_mulhu_latency", lat, 9);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/riscv_seq_alu.md
Name: riscv_seq_alu

Overview:
Parametrised successor to the single-cycle combinational ALU for the multi-cycle RISC-V core. It adds shifts, signed and unsigned compare, and an iterative unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU). Every result is registered, and a valid/ready handshake lets the multi-cycle control FSM stall on long operations.
Latency is 1 cycle for simple ops and WIDTH+1 cycles for multiply/divide.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two and at least 8
SHW, $clog2(WIDTH), derived (localparam); number of shift-amount bits taken from b[SHW-1:0]

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  high when the unit can accept an operation (state IDLE and reset low)
alu_ctl  in  4  operation code, sampled on accept
a  in  WIDTH  operand A, sampled on accept
b  in  WIDTH  operand B, sampled on accept
out_valid  out  1  one-cycle pulse when result/zero are updated
result  out  WIDTH  registered result; held until the next out_valid
zero  out  1  registered, high when result==0
busy  out  1  high while in state ITER

Behaviour:
- Accept occurs when in_valid && in_ready at a rising clock edge; a, b and alu_ctl are captured there.
- alu_ctl codes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 12 XOR.
  - 7 SLT (signed), 8 SLTU; result is 1 or 0, zero-extended.
  - 3 SLL, 4 SRL, 5 SRA; shift amount is b[SHW-1:0].
  - 9 MUL (low WIDTH bits of product), 10 MULHU (high WIDTH bits, unsigned).
  - 11 DIVU, 13 REMU.
  - 14, 15: undefined; result 0, latency 1.
- Arithmetic wraps modulo 2^WIDTH; ADD/SUB carry is discarded.
- Simple ops (everything except 9/10/11/13):
  - result and zero are loaded on the accept edge.
  - out_valid is high for exactly the next cycle.
  - State stays IDLE, so back-to-back accepts every cycle are legal.
- Iterative ops:
  - The accept edge moves IDLE->ITER and loads iteration counter = WIDTH-1.
  - MUL/MULHU: one shift-add step per cycle over a 2*WIDTH accumulator.
  - DIVU/REMU: one restoring-division step per cycle (remainder/quotient registers).
  - On the edge where the counter reaches 0 in ITER, result and zero are loaded and the state moves ITER->IDLE.
  - out_valid is then high for one cycle; first out_valid is WIDTH+1 cycles after the accept edge.
  - in_ready=0 and busy=1 throughout ITER; in_valid is ignored there.
  - in_ready returns high in the out_valid cycle, so a new op may be accepted that cycle.
- Divide by zero (b==0):
  - DIVU result = all ones; REMU result = a (RISC-V semantics).
  - Still takes the full WIDTH+1 latency.
- State machine has two states:
  - IDLE --accept iterative--> ITER.
  - ITER --count==0--> IDLE.
  - No other transitions.
- Reset, asynchronous, takes effect immediately at any time:
  - state=IDLE, counter=0, result=0, zero=0 (internal flag only; port zero is defined below), out_valid=0, busy=0.
  - in_ready=0 while reset is asserted, 1 after release.
- Reset mid-ITER aborts the operation: no out_valid, and result reads 0.
- Port zero reads 1 out of reset, since result=0 there. Zero is defined as (result==0) from the result register, so it is registered in effect.
- out_valid is never asserted without a preceding accept.

Decomposition:
- Shared package riscv_alu_pkg holds:
  - localparam codes ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLL=3, ALU_SRL=4, ALU_SRA=5, ALU_SUB=6, ALU_SLT=7, ALU_SLTU=8, ALU_MUL=9, ALU_MULHU=10, ALU_DIVU=11, ALU_XOR=12, ALU_REMU=13.
  - State encodings ST_IDLE/ST_ITER.
  - Function is_iterative(ctl).
- One sub-module: riscv_iter_muldiv (WIDTH).
  - Contains the shift-add/restoring datapath and counter.
  - Interface: start, op[1:0], a, b, done pulse, res.
- The top holds the simple-op combinational logic, result/valid registers and the FSM.

Test Plan:
- Reset with no ops, WIDTH=32 -> result=0, out_valid=0, busy=0, zero=1; in_ready=0 during reset, 1 one cycle after release.
- Back-to-back ops on consecutive cycles:
  - ADD 0xFFFFFFFF+1 -> result 0, zero=1, out_valid pulse.
  - SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - Each result appears exactly 1 cycle after its accept.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
  - out_valid exactly 33 cycles after accept; busy high 32 cycles; in_valid held high during ITER is not accepted.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 0x12345678/0 -> 0xFFFFFFFF; REMU same operands -> 0x12345678.
- Assert reset 10 cycles into a DIVU -> no out_valid, result=0, in_ready high after release, next ADD 3+4 -> 7.
- WIDTH=8 variant: MUL 0x10*0x10 -> 0x00, zero=1, latency 9 cycles; MULHU same operands -> 0x01.
